vending_machine_ctrl: RTL and testbench
=======================================

Name: vending_machine_ctrl

Overview:
Coin-accepting soda vending controller. Accepts nickel (5c), dime (10c) and quarter (25c) pulses, accumulates credit, and dispenses one soda when credit reaches the price. Returns any overpayment as a count of nickels. Sits between the coin-acceptor front end (one coin pulse per clock) and the dispenser/change-return actuators.

Parameters:
PRICE_NICKELS, 4, soda price in nickels (default 20c); legal range 1..8.

Ports:
clk_i  in  1  system clock; all state updates on rising edge.
rst_i  in  1  asynchronous, active-high reset.
nickle_i  in  1  5c coin accepted this cycle (level sampled once per clock).
dime_i  in  1  10c coin accepted this cycle.
quarter_i  in  1  25c coin accepted this cycle.
soda_o  out  1  registered one-cycle pulse: dispense one soda.
change_o  out  3  registered change in nickels, valid in the same cycle as soda_o, else 0.

Behaviour:
- Reset (rst_i high, asynchronous): credit = 0, soda_o = 0, change_o = 0. Held while rst_i is high.
- Internal state: credit register, 0..PRICE_NICKELS-1 nickels, one-hot encoded, 8 bits. Bit k set means credit is k nickels; bits at or above PRICE_NICKELS are never set.
- Coin value per cycle: nickle_i = 1 nickel, dime_i = 2, quarter_i = 5.
- Exactly one coin input high: sum = credit + value.
  - If sum < PRICE_NICKELS: credit <= sum; soda_o <= 0; change_o <= 0.
  - If sum >= PRICE_NICKELS: credit <= 0; soda_o <= 1; change_o <= sum - PRICE_NICKELS.
- Maximum change is (PRICE_NICKELS-1)+5-PRICE_NICKELS = 4, so it always fits in 3 bits.
- No coin input high: credit holds; soda_o <= 0; change_o <= 0.
- Two or more coin inputs high in the same cycle: the cycle is illegal and all coins are ignored. Credit holds, soda_o <= 0, change_o <= 0, and no coin is refunded.
- Latency: exactly one clock from the sampling edge of the coin to the soda_o/change_o pulse.
- Back-to-back vends are allowed. A coin arriving in the same cycle that soda_o is high is credited against a fresh credit of 0.
- soda_o and change_o never stay high for more than one cycle per vend. change_o is nonzero only when soda_o = 1.
- Reset asserted mid-accumulation discards credit with no refund.
- Coin-per-cycle assumption: the same level held for N cycles counts as N coins. Edge detection is the front end's responsibility.

Optional Feature:
Macro VM_STATE_OUT_EN.
- When defined: adds output port state_o [7:0], equal to the one-hot credit register. Reset value is 8'b0000_0001.
- When undefined: the port is absent and function is otherwise identical.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> soda_o = 0, change_o = 0, credit = 0 immediately; state_o = 8'h01 when VM_STATE_OUT_EN is defined.
- Exact payment: dime, dime on consecutive cycles -> soda_o = 1 with change_o = 0 one cycle after the second dime, then soda_o = 0.
- Overpay: nickel, nickel, nickel, then quarter -> soda_o = 1 with change_o = 4 (20c) one cycle after the quarter; credit returns to 0.
- Single quarter from 0 credit -> soda_o = 1, change_o = 1; next cycle outputs are 0.
- Illegal input: credit 2 nickels, then dime_i = quarter_i = 1 together -> no vend, credit stays 2; a following dime then vends with change_o = 0.
- Idle and random: no coins for 10 cycles leaves credit unchanged. Then 200 cycles of random single coins or idle -> scoreboard model matches soda_o and change_o every cycle.

Source files
------------

// File: rtl/vending_machine_ctrl.sv
// Coin-accepting soda vending controller with a one-hot credit register and
// registered vend/change pulses. Define VM_STATE_OUT_EN to expose the credit register as state_o.
module vending_machine_ctrl #(
    parameter int PRICE_NICKELS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       nickle_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic       soda_o,
    output logic [2:0] change_o
`ifdef VM_STATE_OUT_EN
    ,
    output logic [7:0] state_o
`endif
);

    localparam logic [3:0] PRICE = 4'(PRICE_NICKELS);

    typedef enum logic [7:0] {
        CREDIT_0 = 8'h01,
        CREDIT_1 = 8'h02,
        CREDIT_2 = 8'h04,
        CREDIT_3 = 8'h08,
        CREDIT_4 = 8'h10,
        CREDIT_5 = 8'h20,
        CREDIT_6 = 8'h40,
        CREDIT_7 = 8'h80
    } credit_e;

    credit_e    credit_q, credit_d;
    logic       soda_q, soda_d;
    logic [2:0] change_q, change_d;

    logic [3:0] credit_n;
    logic [3:0] coin_value;
    logic       coin_legal;
    logic [3:0] sum;

    function automatic credit_e encode_credit(input logic [3:0] n);
        case (n)
            4'd1:    return CREDIT_1;
            4'd2:    return CREDIT_2;
            4'd3:    return CREDIT_3;
            4'd4:    return CREDIT_4;
            4'd5:    return CREDIT_5;
            4'd6:    return CREDIT_6;
            4'd7:    return CREDIT_7;
            default: return CREDIT_0;
        endcase
    endfunction

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        credit_n   = 4'd0;
        coin_value = 4'd0;
        coin_legal = 1'b0;
        credit_d   = credit_q;
        soda_d     = 1'b0;
        change_d   = 3'd0;

        case (credit_q)
            CREDIT_1: credit_n = 4'd1;
            CREDIT_2: credit_n = 4'd2;
            CREDIT_3: credit_n = 4'd3;
            CREDIT_4: credit_n = 4'd4;
            CREDIT_5: credit_n = 4'd5;
            CREDIT_6: credit_n = 4'd6;
            CREDIT_7: credit_n = 4'd7;
            default:  credit_n = 4'd0;
        endcase

        // Simultaneous coins are treated as a jammed acceptor and dropped.
        case ({quarter_i, dime_i, nickle_i})
            3'b001: begin coin_value = 4'd1; coin_legal = 1'b1; end
            3'b010: begin coin_value = 4'd2; coin_legal = 1'b1; end
            3'b100: begin coin_value = 4'd5; coin_legal = 1'b1; end
            default: begin coin_value = 4'd0; coin_legal = 1'b0; end
        endcase

        sum = credit_n + coin_value;

        if (coin_legal) begin
            if (sum >= PRICE) begin
                credit_d = CREDIT_0;
                soda_d   = 1'b1;
                change_d = 3'(sum - PRICE);
            end else begin
                credit_d = encode_credit(sum);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= CREDIT_0;
            soda_q   <= 1'b0;
            change_q <= 3'd0;
        end else begin
            credit_q <= credit_d;
            soda_q   <= soda_d;
            change_q <= change_d;
        end
    end

    assign soda_o   = soda_q;
    assign change_o = change_q;
`ifdef VM_STATE_OUT_EN
    assign state_o  = credit_q;
`endif

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Scoreboard bench for vending_machine_ctrl: an integer credit model pushes the
// expected vend/change each cycle and the sampled DUT outputs are popped against it.
module tb_vending_machine_ctrl;

    localparam int PRICE = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       nickle_i = 1'b0;
    logic       dime_i = 1'b0;
    logic       quarter_i = 1'b0;
    logic       soda_o;
    logic [2:0] change_o;
`ifdef VM_STATE_OUT_EN
    logic [7:0] state_o;
`endif

    int checks = 0;
    int failures = 0;
    int model_credit = 0;

    typedef struct packed {
        logic       soda;
        logic [2:0] change;
        logic [3:0] credit;
    } exp_t;

    exp_t exp_q[$];

    vending_machine_ctrl #(.PRICE_NICKELS(PRICE)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .nickle_i (nickle_i),
        .dime_i   (dime_i),
        .quarter_i(quarter_i),
        .soda_o   (soda_o),
        .change_o (change_o)
`ifdef VM_STATE_OUT_EN
        ,
        .state_o  (state_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of coins, predict the result, then pop and compare after the edge.
    task automatic cycle(input string tag, input logic n, input logic d, input logic q);
        int   value;
        int   sum;
        exp_t e;
        nickle_i  = n;
        dime_i    = d;
        quarter_i = q;
        e = '0;
        value = -1;
        if ({q, d, n} == 3'b001) value = 1;
        if ({q, d, n} == 3'b010) value = 2;
        if ({q, d, n} == 3'b100) value = 5;
        if (value > 0) begin
            sum = model_credit + value;
            if (sum >= PRICE) begin
                model_credit = 0;
                e.soda   = 1'b1;
                e.change = 3'(sum - PRICE);
            end else begin
                model_credit = sum;
            end
        end
        e.credit = 4'(model_credit);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        checks++;
        assert (exp_q.size() == 1)
        else begin
            failures++;
            $error("FAIL %s_queue observed=%0d expected=1", tag, exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_soda"}, {7'd0, soda_o}, {7'd0, e.soda});
            check({tag, "_change"}, {5'd0, change_o}, {5'd0, e.change});
`ifdef VM_STATE_OUT_EN
            check({tag, "_state"}, state_o, 8'(1 << e.credit));
`endif
        end
        nickle_i  = 1'b0;
        dime_i    = 1'b0;
        quarter_i = 1'b0;
    endtask

    initial begin
        int r;

        // Reset held across edges.
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_soda", {7'd0, soda_o}, 8'd0);
        check("reset_change", {5'd0, change_o}, 8'd0);
`ifdef VM_STATE_OUT_EN
        check("reset_state", state_o, 8'h01);
`endif
        rst_i = 1'b0;

        // Exact payment, then the pulse drops.
        cycle("exact_d1", 1'b0, 1'b1, 1'b0);
        cycle("exact_d2", 1'b0, 1'b1, 1'b0);
        check("exact_vend", {7'd0, soda_o}, 8'd1);
        cycle("exact_after", 1'b0, 1'b0, 1'b0);

        // Overpay: three nickels then a quarter -> change 4.
        cycle("over_n1", 1'b1, 1'b0, 1'b0);
        cycle("over_n2", 1'b1, 1'b0, 1'b0);
        cycle("over_n3", 1'b1, 1'b0, 1'b0);
        cycle("over_q", 1'b0, 1'b0, 1'b1);
        check("over_change4", {5'd0, change_o}, 8'd4);
        cycle("over_after", 1'b0, 1'b0, 1'b0);

        // Single quarter from zero credit.
        cycle("quarter", 1'b0, 1'b0, 1'b1);
        check("quarter_change1", {5'd0, change_o}, 8'd1);
        cycle("quarter_after", 1'b0, 1'b0, 1'b0);

        // Illegal: credit 2, dime+quarter together ignored, then a dime vends exactly.
        cycle("illegal_d", 1'b0, 1'b1, 1'b0);
        cycle("illegal_dq", 1'b0, 1'b1, 1'b1);
        check("illegal_no_vend", {7'd0, soda_o}, 8'd0);
        cycle("illegal_d2", 1'b0, 1'b1, 1'b0);
        check("illegal_then_vend", {7'd0, soda_o}, 8'd1);
        check("illegal_then_change0", {5'd0, change_o}, 8'd0);

        // Back-to-back: quarter in the cycle soda_o is high counts against zero credit.
        cycle("b2b_q", 1'b0, 1'b0, 1'b1);
        check("b2b_vend", {7'd0, soda_o}, 8'd1);

        // Idle with credit 3 held over ten cycles, then a nickel vends with no change.
        cycle("idle_n1", 1'b1, 1'b0, 1'b0);
        cycle("idle_d", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 1'b0, 1'b0);
        cycle("idle_n2", 1'b1, 1'b0, 1'b0);
        check("idle_kept_credit", {7'd0, soda_o}, 8'd1);

        // Asynchronous reset mid-cycle right after a vend, with credit pending afterwards.
        cycle("rst_q", 1'b0, 1'b0, 1'b1);
        cycle("rst_d", 1'b0, 1'b1, 1'b0);
        cycle("rst_n", 1'b1, 1'b0, 1'b1);
        cycle("rst_q2", 1'b0, 1'b0, 1'b1);
        #2;
        rst_i = 1'b1;
        model_credit = 0;
        #1;
        check("async_rst_soda", {7'd0, soda_o}, 8'd0);
        check("async_rst_change", {5'd0, change_o}, 8'd0);
`ifdef VM_STATE_OUT_EN
        check("async_rst_state", state_o, 8'h01);
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle("post_rst_d1", 1'b0, 1'b1, 1'b0);
        cycle("post_rst_n", 1'b1, 1'b0, 1'b0);
        check("post_rst_no_vend", {7'd0, soda_o}, 8'd0);
        cycle("post_rst_n2", 1'b1, 1'b0, 1'b0);
        check("post_rst_vend", {7'd0, soda_o}, 8'd1);

        // Random single coins or idle.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 3));
            cycle("rand", r == 1, r == 2, r == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
